systolic_array_ctrl: RTL and testbench
======================================

# systolic_array_ctrl

Sequencing controller for the N×N weight-stationary systolic array built from the team's pipelined `PE` (x flows right, partial sums flow down). On `start` it loads one weight row per cycle into the array's weight registers. It then streams `num_vec` activation vectors with per-row skew while holding the array enable. Finally it emits per-column result-capture strobes timed to the array's pipeline latency.

## Interface
Parameters:
- `N`, 4, array dimension (rows = columns = N), N ≥ 2
- `VEC_W`, 8, width of vector count and all vector addresses

Ports:
- `clk`  in  1  clock (one clock domain); reset is synchronous, active-high
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  single-cycle request; accepted only in IDLE
- `abort`  in  1  synchronous abort; returns to IDLE without `done`
- `num_vec`  in  VEC_W  number of activation vectors; sampled on accepted `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse on normal completion
- `w_ld`  out  1  weight-row load strobe
- `w_row`  out  clog2(N)  weight row index being loaded
- `array_en`  out  1  drives `en` of every PE
- `act_rd`  out  N  per-row activation read enable (bit r = array row r)
- `act_addr`  out  N*VEC_W  per-row vector index; row r occupies bits [r*VEC_W +: VEC_W]
- `res_we`  out  N  per-column result-capture strobe (bit c = column c bottom output)
- `res_addr`  out  N*VEC_W  per-column vector index of captured result; same packing

## Operation
- States: IDLE → LOAD_W → RUN → DONE → IDLE.
- IDLE: all outputs 0. `start`=1 latches `num_vec` into `nv`.
  - `nv`≠0: next state LOAD_W.
  - `nv`=0: next state DONE.
- LOAD_W: N cycles, counter k = 0..N-1. `w_ld`=1, `w_row`=k. `array_en`=0 so PEs hold state. After k=N-1, go to RUN with t=0.
- RUN: cycle counter t from 0 to T_END = nv + 3N, inclusive. `array_en`=1 for every RUN cycle.
  - Row r: `act_rd[r]`=1 and its `act_addr` = t−r when 0 ≤ t−r < nv; otherwise `act_rd[r]`=0 and its `act_addr`=0.
  - The datapath registers activation data, so the row-r element appears on x_in of PE(r,0) at cycle t+1. The datapath drives x_in=0 when the registered read enable is 0.
  - Column c: `res_we[c]`=1 and its `res_addr` = v when t = v + N + 3 + 2c for some 0 ≤ v < nv; otherwise both are 0.
  - Derivation, fixed by the PE pipeline: x hop = 2 cycles per column; mult-to-p_sum = 1 cycle; row-to-row p_sum skew = 1 cycle.
  - After t = T_END, go to DONE.
- DONE: `done`=1 for one cycle and `busy`=1; all other outputs 0. Next state IDLE. `start` is ignored in DONE.
- `abort`=1 in any non-IDLE state: next cycle is IDLE, all outputs 0, no `done`. `abort` has priority over the normal transition.
- `start` in any non-IDLE state is ignored. `nv` does not change while busy.
- `rst` has priority over everything. Next cycle: IDLE, counters 0, all outputs 0.
- Counter t width: VEC_W + clog2(3N+1) + 1 bits; no wrap for any `num_vec` ≤ 2^VEC_W − 1.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Accepted `start` at cycle S: `w_ld` is high during S+1..S+N. RUN t=0 is cycle S+N+1.
- First `act_rd[0]` is at t=0. First `res_we[0]` is at t=N+3. Last strobe is `res_we[N-1]` for v=nv−1, at t=T_END.
- `done` is at cycle S+N+1+T_END+1. `busy` is high from S+1 through the `done` cycle.
- `num_vec`=0: `done` at S+1 with `busy`=1 that cycle; no `w_ld`, no `array_en`.
- `act_rd`/`res_we` bits for different rows/columns can be high in the same cycle; every listed condition is evaluated independently.

## Test plan
- N=4, `num_vec`=1, `start` at cycle 0 → `w_ld` with rows 0..3 in cycles 1..4; `act_rd` rows 0..3 in cycles 5..8, all with addr 0; `res_we[c]` at cycle 5+7+2c (12,14,16,18), addr 0; T_END=13; `done` at cycle 19.
- N=4, `num_vec`=3 → row 2 reads vectors 0,1,2 at t=2,3,4; `res_we[1]` at t=9,10,11 with addr 0,1,2; `array_en` high for exactly 16 cycles; single `done`.
- `start` pulsed during LOAD_W, during RUN, and during the `done` cycle → all ignored; one `start` in the following IDLE cycle is accepted.
- `num_vec`=0 → `done` one cycle after `start`; `w_ld`, `array_en`, `act_rd` and `res_we` never assert.
- `abort` at RUN t=6 with `num_vec`=5 → next cycle IDLE, all outputs 0, `done` never pulses; a new `start` then runs a full normal sequence.
- `rst` asserted during LOAD_W k=2 and again during RUN → next cycle every output is 0 and the state is IDLE; an immediately following `start` produces timing identical to the first test.

Source files
------------

// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - weight-load / activation-stream / result-capture sequencer for an NxN systolic array
module systolic_array_ctrl #(
  parameter int N     = 4,
  parameter int VEC_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [VEC_W-1:0]       num_vec,
  output logic                   busy,
  output logic                   done,
  output logic                   w_ld,
  output logic [$clog2(N)-1:0]   w_row,
  output logic                   array_en,
  output logic [N-1:0]           act_rd,
  output logic [N*VEC_W-1:0]     act_addr,
  output logic [N-1:0]           res_we,
  output logic [N*VEC_W-1:0]     res_addr
);

  localparam int KW = $clog2(N);
  // Wide enough to hold nv + 3N for the largest vector count without wrapping.
  localparam int TW = VEC_W + $clog2(3*N+1) + 1;
  localparam logic [TW-1:0] THREE_N = TW'(3*N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_W,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [TW-1:0]      t_q, t_d;
  logic [VEC_W-1:0]   nv_q, nv_d;
  logic [TW-1:0]      t_end;
  logic [TW-1:0]      nv_ext_d;

  logic               busy_d, done_d, w_ld_d, array_en_d;
  logic [KW-1:0]      w_row_d;
  logic [N-1:0]       act_rd_d, res_we_d;
  logic [N*VEC_W-1:0] act_addr_d, res_addr_d;
  logic [TW-1:0]      diff;

  assign t_end    = {{(TW-VEC_W){1'b0}}, nv_q} + THREE_N;
  assign nv_ext_d = {{(TW-VEC_W){1'b0}}, nv_d};

  // Next-state and counter update; abort from any busy state overrides the normal transition.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    nv_d    = nv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nv_d    = num_vec;
          k_d     = '0;
          t_d     = '0;
          state_d = (num_vec != '0) ? S_LOAD_W : S_DONE;
        end
      end
      S_LOAD_W: begin
        if (k_q == KW'(N-1)) begin
          state_d = S_RUN;
          k_d     = '0;
          t_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_RUN: begin
        if (t_q == t_end) begin
          state_d = S_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      k_d     = '0;
      t_d     = '0;
    end
  end

  // Output decode from the next state so every strobe can be registered and line up with its state.
  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    w_ld_d     = 1'b0;
    w_row_d    = '0;
    array_en_d = 1'b0;
    act_rd_d   = '0;
    act_addr_d = '0;
    res_we_d   = '0;
    res_addr_d = '0;
    diff       = '0;
    case (state_d)
      S_LOAD_W: begin
        busy_d  = 1'b1;
        w_ld_d  = 1'b1;
        w_row_d = k_d;
      end
      S_RUN: begin
        busy_d     = 1'b1;
        array_en_d = 1'b1;
        // Row r is skewed by r cycles so its data meets the partial sum coming down.
        for (int r = 0; r < N; r++) begin
          diff = t_d - TW'(r);
          if (t_d >= TW'(r) && diff < nv_ext_d) begin
            act_rd_d[r]                  = 1'b1;
            act_addr_d[r*VEC_W +: VEC_W] = diff[VEC_W-1:0];
          end
        end
        // Column c result leaves the bottom N+3+2c cycles after vector v entered row 0.
        for (int c = 0; c < N; c++) begin
          diff = t_d - TW'(N + 3 + 2*c);
          if (t_d >= TW'(N + 3 + 2*c) && diff < nv_ext_d) begin
            res_we_d[c]                  = 1'b1;
            res_addr_d[c*VEC_W +: VEC_W] = diff[VEC_W-1:0];
          end
        end
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      t_q      <= '0;
      nv_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      w_ld     <= 1'b0;
      w_row    <= '0;
      array_en <= 1'b0;
      act_rd   <= '0;
      act_addr <= '0;
      res_we   <= '0;
      res_addr <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      t_q      <= t_d;
      nv_q     <= nv_d;
      busy     <= busy_d;
      done     <= done_d;
      w_ld     <= w_ld_d;
      w_row    <= w_row_d;
      array_en <= array_en_d;
      act_rd   <= act_rd_d;
      act_addr <= act_addr_d;
      res_we   <= res_we_d;
      res_addr <= res_addr_d;
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb/tb_systolic_array_ctrl.sv - self-checking bench for systolic_array_ctrl
module tb_systolic_array_ctrl;

  localparam int N  = 4;
  localparam int VW = 8;
  localparam int KW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [VW-1:0]     num_vec;
  logic              busy, done, w_ld, array_en;
  logic [KW-1:0]     w_row;
  logic [N-1:0]      act_rd, res_we;
  logic [N*VW-1:0]   act_addr, res_addr;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one outstanding sequence, described by its start cycle and vector count.
  bit active = 1'b0;
  int s_cyc  = 0;
  int m_nv   = 0;

  systolic_array_ctrl #(.N(N), .VEC_W(VW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .num_vec  (num_vec),
    .busy     (busy),
    .done     (done),
    .w_ld     (w_ld),
    .w_row    (w_row),
    .array_en (array_en),
    .act_rd   (act_rd),
    .act_addr (act_addr),
    .res_we   (res_we),
    .res_addr (res_addr)
  );

  always #5 clk = ~clk;

  // Cycle index; cycle c spans the interval after the c-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int done_rel();
    return (m_nv == 0) ? 1 : (N + 2 + m_nv + 3*N);
  endfunction

  task automatic check_outputs();
    int rel, tend, t, d;
    logic            e_busy, e_done, e_wld, e_en;
    logic [KW-1:0]   e_wrow;
    logic [N-1:0]    e_act, e_res;
    logic [N*VW-1:0] e_aa, e_ra;
    e_busy = 0; e_done = 0; e_wld = 0; e_en = 0; e_wrow = '0;
    e_act = '0; e_res = '0; e_aa = '0; e_ra = '0;
    rel = cyc - s_cyc;
    if (active && rel > done_rel()) active = 1'b0;
    if (active) begin
      tend = m_nv + 3*N;
      if (m_nv == 0) begin
        if (rel == 1) begin e_busy = 1; e_done = 1; end
      end else if (rel >= 1 && rel <= N) begin
        e_busy = 1; e_wld = 1; e_wrow = KW'(rel - 1);
      end else if (rel >= N + 1 && rel <= N + 1 + tend) begin
        t = rel - N - 1;
        e_busy = 1; e_en = 1;
        for (int r = 0; r < N; r++) begin
          d = t - r;
          if (d >= 0 && d < m_nv) begin e_act[r] = 1; e_aa[r*VW +: VW] = VW'(d); end
        end
        for (int c = 0; c < N; c++) begin
          d = t - (N + 3 + 2*c);
          if (d >= 0 && d < m_nv) begin e_res[c] = 1; e_ra[c*VW +: VW] = VW'(d); end
        end
      end else if (rel == N + 2 + tend) begin
        e_busy = 1; e_done = 1;
      end
    end
    check("busy",     64'(busy),     64'(e_busy));
    check("done",     64'(done),     64'(e_done));
    check("w_ld",     64'(w_ld),     64'(e_wld));
    check("w_row",    64'(w_row),    64'(e_wrow));
    check("array_en", 64'(array_en), 64'(e_en));
    check("act_rd",   64'(act_rd),   64'(e_act));
    check("act_addr", 64'(act_addr), 64'(e_aa));
    check("res_we",   64'(res_we),   64'(e_res));
    check("res_addr", 64'(res_addr), 64'(e_ra));
  endtask

  // Check the current cycle, then apply inputs for it and advance the model.
  task automatic step(input logic st, input logic ab, input logic rs, input logic [VW-1:0] nvv);
    int  rel;
    bit  busy_now;
    @(negedge clk);
    check_outputs();
    rel      = cyc - s_cyc;
    busy_now = active && rel >= 1 && rel <= done_rel();
    start    = st;
    abort    = ab;
    rst      = rs;
    num_vec  = nvv;
    if (rs) active = 1'b0;
    else if (busy_now && ab) active = 1'b0;
    else if (!busy_now && st) begin
      active = 1'b1;
      s_cyc  = cyc;
      m_nv   = int'(nvv);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, VW'($urandom));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_vec = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single vector, full sequence.
    step(1'b1, 1'b0, 1'b0, 8'd1);
    idle(22);

    // Three vectors.
    step(1'b1, 1'b0, 1'b0, 8'd3);
    idle(24);

    // Starts during LOAD_W, RUN and the done cycle are ignored; the next idle one is taken.
    for (int i = 0; i <= 21; i++)
      step((i == 0 || i == 2 || i == 8 || i == 20 || i == 21), 1'b0, 1'b0,
           (i == 21) ? 8'd1 : 8'd2);
    idle(22);

    // Zero vectors.
    step(1'b1, 1'b0, 1'b0, 8'd0);
    idle(4);

    // Abort at RUN t=6, then a full normal sequence.
    step(1'b1, 1'b0, 1'b0, 8'd5);
    idle(10);
    step(1'b0, 1'b1, 1'b0, 8'd0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 8'd2);
    idle(24);

    // Reset during LOAD_W k=2, then immediate restart.
    step(1'b1, 1'b0, 1'b0, 8'd4);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd1);
    idle(22);

    // Reset during RUN, then immediate restart.
    step(1'b1, 1'b0, 1'b0, 8'd4);
    idle(8);
    step(1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd1);
    idle(22);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic          st, ab, rs;
      logic [VW-1:0] nvv;
      st  = ($urandom_range(0, 5) == 0);
      ab  = ($urandom_range(0, 79) == 0);
      rs  = ($urandom_range(0, 199) == 0);
      nvv = ($urandom_range(0, 9) == 0) ? VW'($urandom_range(0, 255)) : VW'($urandom_range(0, 6));
      step(st, ab, rs, nvv);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
